clock_disp_scan: RTL and testbench

Six-digit multiplexed seven-segment scan driver for the 12-hour clock. It sits directly downstream of the seconds, minutes and hours BCD counters. It takes their packed-BCD outputs and the PM flag and drives a common-anode, active-low, 6-digit HH:MM:SS display, one digit at a time. The displayed time is captured once per frame so a frame never mixes old and new values. The block also handles hours leading-zero blanking, colon blink and the PM indicator.

---
 rtl/clock_disp_scan.sv | 161 ++++++++++++++++
 tb/tb_clock_disp_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/clock_disp_scan.sv
// clock_disp_scan: six-digit multiplexed seven-segment scan driver for the
// 12-hour HH:MM:SS clock. The displayed time is captured once per frame, so
// one frame never mixes old and new values. The block also handles hours
// leading-zero blanking, the blinking colon and the PM dot.
// The outputs are common-anode and active low.
// The outputs are registered and show the counter and snapshot state of the
// previous cycle.

module clock_disp_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       pm,
    input  logic       blank,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_digit;
    logic [7:0]       r_snap_hh;
    logic [7:0]       r_snap_mm;
    logic [7:0]       r_snap_ss;
    logic             r_snap_pm;

    logic [5:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_start;

    logic             w_div_last;
    logic             w_frame_end;
    logic             w_frame_first;
    logic [3:0]       w_nibble;
    logic [6:0]       w_seg_dec;
    logic [5:0]       w_an_sel;
    logic             w_lead_zero;
    logic             w_dp;

    assign w_div_last    = (r_div == DIV_LAST);
    assign w_frame_end   = w_div_last && (r_digit == 3'd5);
    assign w_frame_first = (r_div == '0) && (r_digit == 3'd0);

    // Dwell counter and digit index; digit steps when the dwell count expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div   <= '0;
            r_digit <= 3'd0;
        end else if (w_div_last) begin
            r_div   <= '0;
            r_digit <= (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
        end else begin
            r_div   <= r_div + DIV_W'(1);
        end
    end

    // Capture the time on the last cycle of a frame so the next frame is coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap_hh <= 8'h00;
            r_snap_mm <= 8'h00;
            r_snap_ss <= 8'h00;
            r_snap_pm <= 1'b0;
        end else if (w_frame_end) begin
            r_snap_hh <= hh;
            r_snap_mm <= mm;
            r_snap_ss <= ss;
            r_snap_pm <= pm;
        end
    end

    // Select the nibble, anode and decimal point for the current digit.
    always_comb begin
        w_nibble    = 4'h0;
        w_dp        = 1'b1;
        w_an_sel    = ~(6'b000001 << r_digit);
        w_lead_zero = 1'b0;
        case (r_digit)
            3'd0: begin
                w_nibble = r_snap_ss[3:0];
                w_dp     = ~r_snap_pm;
            end
            3'd1: w_nibble = r_snap_ss[7:4];
            3'd2: begin
                w_nibble = r_snap_mm[3:0];
                w_dp     = r_snap_ss[0];
            end
            3'd3: w_nibble = r_snap_mm[7:4];
            3'd4: begin
                w_nibble = r_snap_hh[3:0];
                w_dp     = r_snap_ss[0];
            end
            3'd5: begin
                w_nibble    = r_snap_hh[7:4];
                w_lead_zero = (r_snap_hh[7:4] == 4'h0);
            end
            default: begin
                w_nibble = 4'h0;
                w_dp     = 1'b1;
            end
        endcase
    end

    // Active-low seven-segment decode {g,f,e,d,c,b,a}; codes A-F show a dash.
    always_comb begin
        w_seg_dec = 7'h3F;
        case (w_nibble)
            4'h0:    w_seg_dec = 7'h40;
            4'h1:    w_seg_dec = 7'h79;
            4'h2:    w_seg_dec = 7'h24;
            4'h3:    w_seg_dec = 7'h30;
            4'h4:    w_seg_dec = 7'h19;
            4'h5:    w_seg_dec = 7'h12;
            4'h6:    w_seg_dec = 7'h02;
            4'h7:    w_seg_dec = 7'h78;
            4'h8:    w_seg_dec = 7'h00;
            4'h9:    w_seg_dec = 7'h10;
            default: w_seg_dec = 7'h3F;
        endcase
    end

    // Output register stage; blank and the leading zero only mask the drive, never the scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an          <= 6'h3F;
            r_seg         <= 7'h7F;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_first;
            if (blank) begin
                r_an  <= 6'h3F;
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end else if (w_lead_zero) begin
                r_an  <= 6'h3F;
                r_seg <= 7'h7F;
                r_dp  <= w_dp;
            end else begin
                r_an  <= w_an_sel;
                r_seg <= w_seg_dec;
                r_dp  <= w_dp;
            end
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Bench for clock_disp_scan with SCAN_DIV = 4. The stimulus pushes one
// hand-computed expected output word per clock. A monitor pops one word per
// clock and compares it on the falling edge.

module tb_clock_disp_scan;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       blank;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
        int         frm;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   frame_id = 0;

    always #5 clk = ~clk;

    clock_disp_scan #(.SCAN_DIV(SD)) dut (
        .clk         (clk),
        .reset       (reset),
        .hh          (hh),
        .mm          (mm),
        .ss          (ss),
        .pm          (pm),
        .blank       (blank),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    function automatic logic [5:0] an_of(input int d);
        case (d)
            0:       an_of = 6'h3E;
            1:       an_of = 6'h3D;
            2:       an_of = 6'h3B;
            3:       an_of = 6'h37;
            4:       an_of = 6'h2F;
            default: an_of = 6'h1F;
        endcase
    endfunction

    // One clock: the entry describes the outputs registered at this rising edge.
    task automatic cyc(input exp_t e);
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    task automatic push_reset_cycle();
        exp_t e;
        e.an  = 6'h3F;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fs  = 1'b0;
        e.frm = frame_id;
        e.cyc = -1;
        cyc(e);
    endtask

    // segs = {d5,d4,d3,d2,d1,d0} codes, dps bit d = dp of digit d, lz = hide digit 5.
    task automatic push_frame(input logic [41:0] segs, input logic [5:0] dps, input bit lz,
                              input int bl_start, input int bl_len, input int ncyc);
        frame_id++;
        for (int i = 0; i < ncyc; i++) begin
            int   d;
            exp_t e;
            d     = i / SD;
            blank = (i >= bl_start) && (i < bl_start + bl_len);
            e.fs  = (i == 0);
            e.frm = frame_id;
            e.cyc = i;
            if (blank || (lz && d == 5)) begin
                e.an  = 6'h3F;
                e.seg = 7'h7F;
                e.dp  = 1'b1;
            end else begin
                e.an  = an_of(d);
                e.seg = segs[d*7 +: 7];
                e.dp  = dps[d];
            end
            cyc(e);
        end
        blank = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_start !== e.fs) begin
                n_errors++;
                $display("FAIL scan frame %0d cyc %0d: got an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                         e.frm, e.cyc, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam logic [41:0] SEG_ZERO = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    localparam logic [41:0] SEG_A    = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [41:0] SEG_B    = {7'h40, 7'h10, 7'h30, 7'h19, 7'h12, 7'h78};
    localparam logic [41:0] SEG_E    = {7'h79, 7'h3F, 7'h30, 7'h12, 7'h12, 7'h02};

    initial begin
        reset = 1'b1;
        blank = 1'b0;
        hh    = 8'h12;
        mm    = 8'h34;
        ss    = 8'h56;
        pm    = 1'b1;

        repeat (3) push_reset_cycle();
        reset = 1'b0;

        // Frame 1 shows the cleared snapshot; 12:34:56 PM is captured at its end.
        push_frame(SEG_ZERO, 6'b101011, 1'b1, 0, 0, 24);

        hh = 8'h09; mm = 8'h34; ss = 8'h57; pm = 1'b0;
        push_frame(SEG_A, 6'b101010, 1'b0, 0, 0, 24);

        hh = 8'h12; mm = 8'h34; ss = 8'h56; pm = 1'b0;
        push_frame(SEG_B, 6'b111111, 1'b1, 0, 0, 24);

        // Frame 4 must stay on mm=34 although mm changes while digit 1 is lit.
        fork
            push_frame(SEG_A, 6'b101011, 1'b0, 0, 0, 24);
            begin
                repeat (5) @(posedge clk);
                #2;
                mm = 8'h35;
                hh = 8'h1A;
            end
        join

        hh = 8'h12; mm = 8'h34; ss = 8'h56; pm = 1'b1;
        push_frame(SEG_E, 6'b101011, 1'b0, 0, 0, 24);

        push_frame(SEG_A, 6'b101010, 1'b0, 2, 10, 24);

        // Restart from reset in the middle of digit 3.
        push_frame(SEG_A, 6'b101010, 1'b0, 0, 0, 13);
        reset = 1'b1;
        push_reset_cycle();
        reset = 1'b0;
        push_frame(SEG_ZERO, 6'b101011, 1'b1, 0, 0, 24);

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
